// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit framer: FSM state encoding, line levels, defaults.
// Latency: n/a (package only).
// Backpressure: n/a. Build option UART_TX_STOP2_EN selects two stop bits instead of one.
package uart_tx_pkg;

    // Default payload width in bits per frame.
    localparam int DATA_WIDTH_DEF = 8;

    // Serial line levels.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Number of stop-bit cycles at the end of every frame.
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    // Framer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Total bit periods of one frame for a given payload width and parity setting.
    function automatic int frame_len(input int width, input logic par_en);
        return 1 + width + (par_en ? 1 : 0) + STOP_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter feeding the framer's data slots, LSB first.
// Latency: o_bit is combinational from the register state so the framer can register it with the FSM.
// Backpressure: none; i_load wins over i_shift, shifting stops once the last bit index is reached.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    // DATA_WIDTH must be at least 2: the look-ahead tap reads bit 1.
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit,
    output logic                  o_done
);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_last;

    // r_cnt holds the index of the bit currently on the line; it stops at the last index.
    assign w_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign o_done = w_last;

    // When shifting, the framer is about to put the following bit on the line, so look one ahead.
    assign o_bit = i_shift ? r_shreg[1] : r_shreg[0];

    // Load a fresh payload on acceptance, otherwise advance one bit per shift request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= '0;
        end else if (i_shift && !w_last) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity slot, stop bit(s); one CLK per bit.
// Latency: frame accepted in IDLE is on the line (start bit) one edge later; TX_OUT/Busy are registered.
// Backpressure: Data_Valid is ignored while Busy, except in the last stop cycle (back-to-back). UART_TX_STOP2_EN = two stop bits.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    state_t r_state;
    state_t w_next;
    logic   r_par_en;
    logic   w_load;
    logic   w_shift;
    logic   w_ser_bit;
    logic   w_ser_done;
    logic   w_last_stop;

`ifdef UART_TX_STOP2_EN
    // High during the second stop cycle.
    logic r_stop_cnt;

    // Track which of the two stop cycles is on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stop_cnt <= 1'b0;
        end else begin
            r_stop_cnt <= (r_state == ST_STOP) && (w_next == ST_STOP);
        end
    end

    assign w_last_stop = r_stop_cnt;
`else
    assign w_last_stop = 1'b1;
`endif

    // A new frame is taken whenever the FSM is about to enter START (from IDLE or the last stop cycle).
    assign w_load  = (w_next == ST_START);
    // Shift only between consecutive data cycles; the first data bit comes straight from the load.
    assign w_shift = (r_state == ST_DATA) && (w_next == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (P_DATA),
        .o_bit   (w_ser_bit),
        .o_done  (w_ser_done)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = Data_Valid ? ST_START : ST_IDLE;
            ST_START:  w_next = ST_DATA;
            ST_DATA: begin
                if (w_ser_done) begin
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: w_next = ST_STOP;
            ST_STOP: begin
                if (w_last_stop) begin
                    w_next = Data_Valid ? ST_START : ST_IDLE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register; reset always lands in IDLE so an aborted frame is never resumed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Parity enable is captured with the payload so later PAR_EN changes do not affect the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en <= 1'b0;
        end else if (w_load) begin
            r_par_en <= PAR_EN;
        end
    end

    // Registered line driver: the level for the state being entered, so it changes with the state.
    // par_bit is sampled here on the edge into PARITY, which acts as the parity latch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT <= IDLE_LEVEL;
        end else begin
            case (w_next)
                ST_START:  TX_OUT <= START_BIT;
                ST_DATA:   TX_OUT <= w_ser_bit;
                ST_PARITY: TX_OUT <= par_bit;
                ST_STOP:   TX_OUT <= STOP_BIT;
                default:   TX_OUT <= IDLE_LEVEL;
            endcase
        end
    end

    // Busy covers every non-IDLE state and is registered alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Busy <= 1'b0;
        end else begin
            Busy <= (w_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: directed frames plus randomized frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a. Honours UART_TX_STOP2_EN for the stop-bit count.
module tb_uart_tx_framer;

    localparam int W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         par_bit = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int checks = 0;
    int failures = 0;

    logic obs_tx[$];
    logic obs_busy[$];
    logic obs_pb[$];
    logic exp_tx[$];
    logic exp_busy[$];

    always #5 CLK = ~CLK;

    uart_tx_framer #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // ---------------- reference model (frame level) ----------------
    function automatic void clear_q();
        obs_tx.delete(); obs_busy.delete(); obs_pb.delete();
        exp_tx.delete(); exp_busy.delete();
    endfunction

    // A UART frame: start 0, payload LSB first, optional parity, stop bits of 1; Busy for every bit.
    function automatic void model_frame(input logic [W-1:0] d, input logic pe, input logic pb);
        exp_tx.push_back(1'b0); exp_busy.push_back(1'b1);
        for (int i = 0; i < W; i++) begin
            exp_tx.push_back(d[i]); exp_busy.push_back(1'b1);
        end
        if (pe) begin
            exp_tx.push_back(pb); exp_busy.push_back(1'b1);
        end
        for (int s = 0; s < NSTOP; s++) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b1);
        end
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
        end
    endfunction

    // ---------------- stimulus / capture ----------------
    // Offer a frame in IDLE; returns #1 after the accepting edge (start bit visible).
    task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic pb);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; par_bit = pb; Data_Valid = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Record n cycles of TX_OUT/Busy. Data_Valid is held high for cycles < dv_hold; for cycles
    // < noise_until, Data_Valid, P_DATA, PAR_EN and par_bit are randomized mid-cycle.
    task automatic capture(input int n, input int dv_hold, input int noise_until);
        for (int i = 0; i < n; i++) begin
            obs_tx.push_back(TX_OUT);
            obs_busy.push_back(Busy);
            @(negedge CLK);
            if (i < dv_hold) Data_Valid = 1'b1;
            else if (i < noise_until) Data_Valid = 1'($urandom_range(0, 1));
            else Data_Valid = 1'b0;
            if (i < noise_until) begin
                P_DATA  = W'($urandom);
                PAR_EN  = 1'($urandom_range(0, 1));
                par_bit = 1'($urandom_range(0, 1));
            end
            obs_pb.push_back(par_bit);
            @(posedge CLK); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX_OUT); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        @(negedge CLK); Data_Valid = 1'b1; P_DATA = 8'h00;
        @(posedge CLK); #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy got=%b exp=0", Busy); end
        checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL reset_hold_tx got=%b exp=1", TX_OUT); end
        @(negedge CLK); Data_Valid = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_a5_parity();
        int nb;
        clear_q();
        exp_tx = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef UART_TX_STOP2_EN
        exp_tx.push_back(1'b1);
`endif
        for (int i = 0; i < exp_tx.size(); i++) exp_busy.push_back(1'b1);
        model_idle(3);
        start_frame(8'hA5, 1'b1, 1'b1);
        capture(exp_tx.size(), 0, 0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL a5_tx[%0d] got=%b exp=%b", i, obs_tx[i], exp_tx[i]); end
            checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL a5_busy[%0d] got=%b exp=%b", i, obs_busy[i], exp_busy[i]); end
        end
        nb = 0;
        foreach (obs_busy[i]) if (obs_busy[i] === 1'b1) nb++;
        checks++; if (nb != 10 + NSTOP) begin failures++; $display("FAIL a5_busy_len got=%0d exp=%0d", nb, 10 + NSTOP); end
    endtask

    task automatic test_3c_no_parity();
        clear_q();
        exp_tx = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef UART_TX_STOP2_EN
        exp_tx.push_back(1'b1);
`endif
        for (int i = 0; i < exp_tx.size(); i++) exp_busy.push_back(1'b1);
        model_idle(2);
        start_frame(8'h3C, 1'b0, 1'b1);
        capture(exp_tx.size(), 0, 0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL 3c_tx[%0d] got=%b exp=%b", i, obs_tx[i], exp_tx[i]); end
            checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL 3c_busy[%0d] got=%b exp=%b", i, obs_busy[i], exp_busy[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        clear_q();
        len = 1 + W + NSTOP;
        model_frame(8'h01, 1'b0, 1'b0);
        model_frame(8'h80, 1'b0, 1'b0);
        model_idle(2);
        start_frame(8'h01, 1'b0, 1'b0);
        P_DATA = 8'h80;
        capture(exp_tx.size(), 2 * len - 1, 0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL b2b_tx[%0d] got=%b exp=%b", i, obs_tx[i], exp_tx[i]); end
            checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, obs_busy[i], exp_busy[i]); end
        end
    endtask

    task automatic test_ignore_dv();
        clear_q();
        model_frame(8'h3C, 1'b1, 1'b0);
        model_idle(4);
        start_frame(8'h3C, 1'b1, 1'b0);
        capture(3, 0, 0);
        P_DATA = 8'hFF; PAR_EN = 1'b0;
        capture(exp_tx.size() - 3, 1, 0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL ignore_tx[%0d] got=%b exp=%b", i, obs_tx[i], exp_tx[i]); end
            checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL ignore_busy[%0d] got=%b exp=%b", i, obs_busy[i], exp_busy[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] d;
        d = W'($urandom);
        clear_q();
        start_frame(d, 1'b1, 1'b1);
        capture(4, 0, 0);
        checks++; if (TX_OUT !== d[3]) begin failures++; $display("FAIL rstmid_bit3 got=%b exp=%b", TX_OUT, d[3]); end
        #2 RST = 1'b0;
        #1;
        checks++; if (TX_OUT !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b exp=1", TX_OUT); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
        @(negedge CLK); RST = 1'b1; Data_Valid = 1'b0;
        @(posedge CLK); #1;
        clear_q();
        model_idle(4);
        model_frame(8'h55, 1'b0, 1'b0);
        model_idle(2);
        capture(4, 0, 0);
        start_frame(8'h55, 1'b0, 1'b0);
        capture(exp_tx.size() - 4, 0, 0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rstmid_55_tx[%0d] got=%b exp=%b", i, obs_tx[i], exp_tx[i]); end
            checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL rstmid_55_busy[%0d] got=%b exp=%b", i, obs_busy[i], exp_busy[i]); end
        end
    endtask

    // Random payload/parity; all inputs are disturbed mid-frame except in the last stop cycle.
    // The parity slot carries whatever par_bit was during the last data bit.
    task automatic test_random();
        logic [W-1:0] d;
        logic pe;
        int len;
        for (int f = 0; f < 16; f++) begin
            d   = W'($urandom);
            pe  = 1'($urandom_range(0, 1));
            len = 1 + W + (pe ? 1 : 0) + NSTOP;
            clear_q();
            start_frame(d, pe, 1'($urandom_range(0, 1)));
            capture(len + 2, 0, len - 1);
            model_frame(d, pe, obs_pb[W]);
            model_idle(2);
            for (int i = 0; i < exp_tx.size(); i++) begin
                checks++; if (obs_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rand%0d_tx[%0d] d=%h pe=%b got=%b exp=%b", f, i, d, pe, obs_tx[i], exp_tx[i]); end
                checks++; if (obs_busy[i] !== exp_busy[i]) begin failures++; $display("FAIL rand%0d_busy[%0d] got=%b exp=%b", f, i, obs_busy[i], exp_busy[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5_parity();
        test_3c_no_parity();
        test_back_to_back();
        test_ignore_dv();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
